// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
// Tag entries carry a fixed-width rd field so one struct serves every REG_AW up to REG_AW_MAX.
package pipe_pkg;

  localparam int REG_AW_MAX = 8;

  localparam int FWD_RF    = 0;
  localparam int STAGE_EX  = 1;
  localparam int STAGE_MEM = 2;
  localparam int STAGE_WB  = 3;

  // addi x0, x0, 0 -- the word ID/EX loads when bubble_ex is asserted
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } tag_entry_t;

  localparam tag_entry_t TAG_EMPTY = '0;

  // A source hits a stage when that stage will write it back; x0 never hits.
  function automatic logic tag_hits(input tag_entry_t e, input logic [REG_AW_MAX-1:0] src);
    return e.valid && e.reg_write && (src != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Decode-side bundle between the pipeline and the hazard unit.
// The pipeline is the master; the hazard unit is the slave.
interface pipe_hazard_if #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32,
  parameter int SW         = $clog2(NUM_STAGES + 1)
);

  logic                       id_valid;
  logic [REG_AW-1:0]          id_rs1;
  logic [REG_AW-1:0]          id_rs2;
  logic                       id_rs1_used;
  logic                       id_rs2_used;
  logic [REG_AW-1:0]          id_rd;
  logic                       id_reg_write;
  logic                       id_is_load;
  logic [XLEN-1:0]            rf_data1;
  logic [XLEN-1:0]            rf_data2;
  logic [NUM_STAGES*XLEN-1:0] stage_result;
  logic                       ex_redirect;

  logic                       stall;
  logic                       flush_if_id;
  logic                       bubble_ex;
  logic [SW-1:0]              fwd_sel_a;
  logic [SW-1:0]              fwd_sel_b;
  logic [XLEN-1:0]            op_a;
  logic [XLEN-1:0]            op_b;
  logic [CNT_W-1:0]           stall_count;
  logic [CNT_W-1:0]           flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_load, rf_data1, rf_data2, stage_result, ex_redirect,
    input  stall, flush_if_id, bubble_ex, fwd_sel_a, fwd_sel_b, op_a, op_b,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_load, rf_data1, rf_data2, stage_result, ex_redirect,
    output stall, flush_if_id, bubble_ex, fwd_sel_a, fwd_sel_b, op_a, op_b,
           stall_count, flush_count
  );

endinterface

// File: rtl/pipe_hazard_unit_fwd_mux.sv
// Single-operand forwarding: finds the youngest stage writing the source register,
// selects its result, and flags a load-use hazard when that producer is a load not yet ready.
module pipe_fwd_mux
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int XLEN             = 32,
  parameter int REG_AW           = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SW               = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_AW-1:0]          src,
  input  logic                       src_used,
  input  tag_entry_t                 tags [NUM_STAGES],
  input  logic [XLEN-1:0]            rf_data,
  input  logic [NUM_STAGES*XLEN-1:0] stage_result,
  output logic [SW-1:0]              sel,
  output logic [XLEN-1:0]            operand,
  output logic                       load_use
);

  logic youngest_is_load;
  logic youngest_early;

  // Walk oldest to youngest so the youngest hit overwrites any older one.
  always_comb begin
    sel              = SW'(FWD_RF);
    operand          = rf_data;
    youngest_is_load = 1'b0;
    youngest_early   = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (src_used && tag_hits(tags[k-1], REG_AW_MAX'(src))) begin
        sel              = SW'(k);
        operand          = stage_result[(k-1)*XLEN +: XLEN];
        youngest_is_load = tags[k-1].is_load;
        youngest_early   = (k < LOAD_READY_STAGE);
      end
    end
    load_use = youngest_is_load && youngest_early;
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding beside the decode stage.
// Tracks destination tags of EX..WB, stalls on load-use, flushes on EX redirects.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int XLEN             = 32,
  parameter int REG_AW           = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_W            = 32,
  localparam int SW              = $clog2(NUM_STAGES + 1)
) (
  input logic          clk,
  input logic          reset,
  pipe_hazard_if.slave bus
);

  tag_entry_t       tags [NUM_STAGES];
  tag_entry_t       id_entry;
  logic             load_use_a;
  logic             load_use_b;
  logic             load_use;
  logic             stall;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  pipe_fwd_mux #(
    .NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_AW(REG_AW),
    .LOAD_READY_STAGE(LOAD_READY_STAGE), .SW(SW)
  ) u_fwd_a (
    .src(bus.id_rs1), .src_used(bus.id_rs1_used), .tags(tags),
    .rf_data(bus.rf_data1), .stage_result(bus.stage_result),
    .sel(bus.fwd_sel_a), .operand(bus.op_a), .load_use(load_use_a)
  );

  pipe_fwd_mux #(
    .NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_AW(REG_AW),
    .LOAD_READY_STAGE(LOAD_READY_STAGE), .SW(SW)
  ) u_fwd_b (
    .src(bus.id_rs2), .src_used(bus.id_rs2_used), .tags(tags),
    .rf_data(bus.rf_data2), .stage_result(bus.stage_result),
    .sel(bus.fwd_sel_b), .operand(bus.op_b), .load_use(load_use_b)
  );

  // A redirect squashes the decode instruction, so it overrides any stall.
  always_comb begin
    load_use = bus.id_valid && (load_use_a || load_use_b);
    stall    = load_use && !bus.ex_redirect;
    id_entry = '{valid:     1'b1,
                 rd:        REG_AW_MAX'(bus.id_rd),
                 reg_write: bus.id_reg_write,
                 is_load:   bus.id_is_load};
  end

  assign bus.stall       = stall;
  assign bus.flush_if_id = bus.ex_redirect;
  assign bus.bubble_ex   = load_use || bus.ex_redirect;
  assign bus.stall_count = stall_count;
  assign bus.flush_count = flush_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) tags[k] <= TAG_EMPTY;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      tags[0] <= (bus.id_valid && !stall && !bus.ex_redirect) ? id_entry : TAG_EMPTY;
      for (int k = 1; k < NUM_STAGES; k++) tags[k] <= tags[k-1];
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (bus.ex_redirect && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit; uses a 3-bit counter width so saturation is reachable.
module tb_pipe_hazard_unit;

  localparam int NUM_STAGES       = 3;
  localparam int XLEN             = 32;
  localparam int REG_AW           = 5;
  localparam int LOAD_READY_STAGE = 2;
  localparam int CNT_W            = 3;

  logic clk = 1'b0;
  logic reset;
  int   passCount  = 0;
  int   checkCount = 0;

  pipe_hazard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)) bus ();

  pipe_hazard_unit #(
    .NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_AW(REG_AW),
    .LOAD_READY_STAGE(LOAD_READY_STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic ld, input logic redirect);
    bus.id_valid     = valid;
    bus.id_rs1       = rs1;
    bus.id_rs1_used  = u1;
    bus.id_rs2       = rs2;
    bus.id_rs2_used  = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_is_load   = ld;
    bus.ex_redirect  = redirect;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    bus.rf_data1     = 32'h1111_1111;
    bus.rf_data2     = 32'h2222_2222;
    bus.stage_result = {32'h0000_0004, 32'h0000_00AA, 32'h0000_0007};
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    reset = 1'b1;

    // Reset state with a candidate consumer of x5 in decode
    applyStimulus(1, 5, 1, 5, 1, 6, 1, 0, 0);
    checkOutput("rst_stall", 32'(bus.stall), 32'd0);
    checkOutput("rst_flush", 32'(bus.flush_if_id), 32'd0);
    checkOutput("rst_bubble", 32'(bus.bubble_ex), 32'd0);
    checkOutput("rst_sel_a", 32'(bus.fwd_sel_a), 32'd0);
    checkOutput("rst_op_a", bus.op_a, 32'h1111_1111);
    checkOutput("rst_op_b", bus.op_b, 32'h2222_2222);
    checkOutput("rst_stall_cnt", 32'(bus.stall_count), 32'd0);
    checkOutput("rst_flush_cnt", 32'(bus.flush_count), 32'd0);

    // addi x5,x0,7 ; add x6,x5,x5
    applyStimulus(1, 0, 1, 0, 0, 5, 1, 0, 0);
    checkOutput("addi_stall", 32'(bus.stall), 32'd0);
    nextCycle();
    applyStimulus(1, 5, 1, 5, 1, 6, 1, 0, 0);
    checkOutput("dep_sel_a", 32'(bus.fwd_sel_a), 32'd1);
    checkOutput("dep_sel_b", 32'(bus.fwd_sel_b), 32'd1);
    checkOutput("dep_op_a", bus.op_a, 32'd7);
    checkOutput("dep_op_b", bus.op_b, 32'd7);
    checkOutput("dep_stall", 32'(bus.stall), 32'd0);
    nextCycle();

    // lw x5,0(x1) ; add x6,x5,x1
    applyStimulus(1, 1, 1, 0, 0, 5, 1, 1, 0);
    checkOutput("lw_stall", 32'(bus.stall), 32'd0);
    nextCycle();
    applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0);
    checkOutput("lu_stall", 32'(bus.stall), 32'd1);
    checkOutput("lu_bubble", 32'(bus.bubble_ex), 32'd1);
    checkOutput("lu_flush", 32'(bus.flush_if_id), 32'd0);
    nextCycle();
    bus.stage_result = {32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0007};
    #1;
    checkOutput("lu2_stall", 32'(bus.stall), 32'd0);
    checkOutput("lu2_bubble", 32'(bus.bubble_ex), 32'd0);
    checkOutput("lu2_sel_a", 32'(bus.fwd_sel_a), 32'd2);
    checkOutput("lu2_op_a", bus.op_a, 32'hDEAD_BEEF);
    checkOutput("lu2_stall_cnt", 32'(bus.stall_count), 32'd1);
    nextCycle();

    // x5 in stages 1 and 3, x7 in stage 2
    applyStimulus(1, 0, 1, 0, 0, 5, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 0, 5, 1, 0, 0);
    nextCycle();
    bus.stage_result = {32'h0000_0004, 32'h0000_0077, 32'h0000_0009};
    applyStimulus(1, 5, 1, 7, 1, 12, 1, 0, 0);
    checkOutput("young_sel_a", 32'(bus.fwd_sel_a), 32'd1);
    checkOutput("young_op_a", bus.op_a, 32'd9);
    checkOutput("young_sel_b", 32'(bus.fwd_sel_b), 32'd2);
    checkOutput("young_op_b", bus.op_b, 32'h77);
    nextCycle();

    // Write to x0 must never be forwarded
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 1, 0, 1, 3, 1, 0, 0);
    checkOutput("x0_sel_a", 32'(bus.fwd_sel_a), 32'd0);
    checkOutput("x0_op_a", bus.op_a, 32'h1111_1111);
    checkOutput("x0_sel_b", 32'(bus.fwd_sel_b), 32'd0);
    nextCycle();

    // Load-use coinciding with an EX redirect
    applyStimulus(1, 1, 1, 0, 0, 8, 1, 1, 0);
    nextCycle();
    applyStimulus(1, 8, 1, 0, 0, 9, 1, 0, 1);
    checkOutput("redir_stall", 32'(bus.stall), 32'd0);
    checkOutput("redir_flush", 32'(bus.flush_if_id), 32'd1);
    checkOutput("redir_bubble", 32'(bus.bubble_ex), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("redir_flush_cnt", 32'(bus.flush_count), 32'd1);
    checkOutput("redir_stall_cnt", 32'(bus.stall_count), 32'd1);
    checkOutput("redir_flush_off", 32'(bus.flush_if_id), 32'd0);

    // Reset asserted during a stall, then released
    applyStimulus(1, 1, 1, 0, 0, 9, 1, 1, 0);
    nextCycle();
    applyStimulus(1, 9, 1, 0, 0, 10, 1, 0, 0);
    checkOutput("mid_stall", 32'(bus.stall), 32'd1);
    reset = 1'b0;
    nextCycle();
    checkOutput("inrst_stall", 32'(bus.stall), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("post_stall", 32'(bus.stall), 32'd0);
    checkOutput("post_bubble", 32'(bus.bubble_ex), 32'd0);
    checkOutput("post_sel_a", 32'(bus.fwd_sel_a), 32'd0);
    checkOutput("post_op_a", bus.op_a, 32'h1111_1111);
    checkOutput("post_stall_cnt", 32'(bus.stall_count), 32'd0);
    checkOutput("post_flush_cnt", 32'(bus.flush_count), 32'd0);
    nextCycle();

    // Repeated load-use stalls drive stall_count into saturation at 7
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 1, 1, 0, 0, 10, 1, 1, 0);
      nextCycle();
      if (i == 0) begin
        applyStimulus(0, 10, 1, 0, 0, 11, 1, 0, 0);
        checkOutput("novalid_stall", 32'(bus.stall), 32'd0);
      end
      applyStimulus(1, 10, 1, 0, 0, 11, 1, 0, 0);
      checkOutput($sformatf("sat_stall_%0d", i), 32'(bus.stall), 32'd1);
      nextCycle();
      checkOutput($sformatf("sat_cnt_%0d", i), 32'(bus.stall_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
